// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// state encoding, opcode values and the datapath select encodings.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_JALR1,
      S_JALR2,
      S_LUI,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for register and immediate arithmetic instructions.
// Unsupported funct3 values are flagged so the controller can trap.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_isRtype,
   output logic [2:0] o_aluControl,
   output logic       o_illegal
);

   // Map funct3 (and funct7 bit 5 for register ops) onto an ALU operation;
   // immediate adds never subtract because bit 30 is part of the immediate.
   always_comb begin
      o_aluControl = ALU_ADD;
      o_illegal    = 1'b0;
      case (i_funct3)
         3'b000:  o_aluControl = (i_isRtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
         3'b110:  o_aluControl = ALU_OR;
         3'b111:  o_aluControl = ALU_AND;
         3'b010:  o_aluControl = ALU_SLT;
         default: o_illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core. Steps each instruction
// through fetch, decode, execute, memory and writeback states, drives the
// datapath selects and strobes, and traps on illegal encodings or on a
// memory access that never completes.
module multicycle_controller
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter int unsigned TO_W        = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Opcode,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       InstrDone,
   output logic       Trap,
   output logic       TrapCause
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
   localparam bit              WDOG_ON  = (MEM_TIMEOUT != 0);

   state_t          r_state;
   logic [TO_W-1:0] r_toCount;
   logic            r_trapCause;

   logic [2:0]      w_aluControl;
   logic            w_aluIllegal;
   logic            w_inMem;
   logic            w_timeout;

   alu_decoder u_aluDecoder (
      .i_funct3     (Funct3),
      .i_funct7b5   (Funct7b5),
      .i_isRtype    (Opcode == OP_RTYPE),
      .o_aluControl (w_aluControl),
      .o_illegal    (w_aluIllegal)
   );

   assign w_inMem   = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWRITE);
   assign w_timeout = WDOG_ON && w_inMem && !MemReady && (r_toCount == TO_LIMIT);
   assign TrapCause = r_trapCause;

   // State sequencing plus the memory watchdog; a ready in the limit cycle
   // completes the access because it is tested before the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_toCount   <= '0;
         r_trapCause <= 1'b0;
      end else begin
         if (!WDOG_ON || !w_inMem || MemReady) begin
            r_toCount <= '0;
         end else if (r_toCount != TO_LIMIT) begin
            r_toCount <= r_toCount + TO_W'(1);
         end

         case (r_state)
            S_FETCH: begin
               if (MemReady) begin
                  r_state <= S_DECODE;
               end else if (w_timeout) begin
                  r_state     <= S_TRAP;
                  r_trapCause <= 1'b1;
               end
            end
            S_DECODE: begin
               case (Opcode)
                  OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                  OP_RTYPE:          r_state <= S_EXECR;
                  OP_ITYPE:          r_state <= S_EXECI;
                  OP_BRANCH:         r_state <= S_BEQ;
                  OP_JAL:            r_state <= S_JAL;
                  OP_JALR:           r_state <= S_JALR1;
                  OP_LUI:            r_state <= S_LUI;
                  default: begin
                     r_state     <= S_TRAP;
                     r_trapCause <= 1'b0;
                  end
               endcase
            end
            S_MEMADR: r_state <= (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
               if (MemReady) begin
                  r_state <= S_MEMWB;
               end else if (w_timeout) begin
                  r_state     <= S_TRAP;
                  r_trapCause <= 1'b1;
               end
            end
            S_MEMWRITE: begin
               if (MemReady) begin
                  r_state <= S_FETCH;
               end else if (w_timeout) begin
                  r_state     <= S_TRAP;
                  r_trapCause <= 1'b1;
               end
            end
            S_EXECR, S_EXECI: begin
               if (w_aluIllegal) begin
                  r_state     <= S_TRAP;
                  r_trapCause <= 1'b0;
               end else begin
                  r_state <= S_ALUWB;
               end
            end
            S_MEMWB, S_ALUWB, S_BEQ: r_state <= S_FETCH;
            S_JAL, S_JALR2, S_LUI:   r_state <= S_ALUWB;
            S_JALR1:                 r_state <= S_JALR2;
            S_TRAP:                  r_state <= S_TRAP;
            default:                 r_state <= S_FETCH;
         endcase
      end
   end

   // Moore output decode from the current state; only the memory-ready
   // qualified strobes and the branch PC write look at inputs. Everything
   // is forced low while reset is held so an aborted instruction writes nothing.
   always_comb begin
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUControl = ALU_ADD;
      ImmSrc     = IMM_I;
      InstrDone  = 1'b0;
      Trap       = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               MemReq    = 1'b1;
               IRWrite   = MemReady;
               PCWrite   = MemReady;
               ResultSrc = RES_ALURESULT;
               ALUSrcB   = SRCB_FOUR;
            end
            S_DECODE: begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_IMM;
               ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ImmSrc  = (Opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
               MemReq = 1'b1;
               AdrSrc = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = RES_DATA;
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
               MemReq    = 1'b1;
               MemWrite  = 1'b1;
               AdrSrc    = 1'b1;
               InstrDone = MemReady;
            end
            S_EXECR: begin
               ALUSrcA    = SRCA_RS1;
               ALUControl = w_aluControl;
            end
            S_EXECI: begin
               ALUSrcA    = SRCA_RS1;
               ALUSrcB    = SRCB_IMM;
               ALUControl = w_aluControl;
            end
            S_ALUWB: begin
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA    = SRCA_RS1;
               ALUControl = ALU_SUB;
               PCWrite    = Zero;
               InstrDone  = 1'b1;
            end
            S_JAL, S_JALR2: begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_FOUR;
               PCWrite = 1'b1;
            end
            S_JALR1: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
            end
            S_LUI: begin
               ALUSrcB    = SRCB_IMM;
               ImmSrc     = IMM_U;
               ALUControl = ALU_PASSB;
            end
            S_TRAP:  Trap = 1'b1;
            default: Trap = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle checker for multicycle_controller. Each vector names the
// state the controller should be in for that cycle; an independent output
// table turns that into the full expected output word.
module tb_multicycle_controller;

   typedef enum {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXECR,
      T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_JALR1, T_JALR2, T_LUI, T_TRAP
   } tag_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       zero;
      logic       rdy;
      tag_t       tag;
      logic [2:0] alu;
      logic       cause;
   } vec_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BAD    = 7'b1111111;

   logic       clk;
   logic       rst;
   logic [6:0] Opcode;
   logic [2:0] Funct3;
   logic       Funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;
   logic       InstrDone, Trap, TrapCause;

   int checks;
   int failures;

   vec_t       vecs[$];
   logic [6:0] curOp;
   logic [2:0] curF3;
   logic       curF7;
   logic       curZero;

   multicycle_controller #(
      .MEM_TIMEOUT (4),
      .TO_W        (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Opcode     (Opcode),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .InstrDone  (InstrDone),
      .Trap       (Trap),
      .TrapCause  (TrapCause)
   );

   // Free-running clock, rising edge at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected output word for one cycle in the named state, packed in the
   // same order as the observed word built in checkOutput.
   function automatic logic [20:0] expOut(vec_t v);
      logic memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite;
      logic [1:0] resSrc, srcA, srcB;
      logic [2:0] aluCtl, immSrc;
      logic done, trap, cause;
      memReq = 0; memWrite = 0; adrSrc = 0; irWrite = 0; pcWrite = 0;
      regWrite = 0; resSrc = 2'b00; srcA = 2'b00; srcB = 2'b00;
      aluCtl = 3'b000; immSrc = 3'b000; done = 0; trap = 0; cause = 0;
      case (v.tag)
         T_FETCH: begin
            memReq = 1; irWrite = v.rdy; pcWrite = v.rdy;
            resSrc = 2'b10; srcB = 2'b10;
         end
         T_DECODE: begin
            srcA = 2'b01; srcB = 2'b01; immSrc = 3'b010;
         end
         T_MEMADR: begin
            srcA = 2'b10; srcB = 2'b01;
            immSrc = (v.op == OPC_STORE) ? 3'b001 : 3'b000;
         end
         T_MEMREAD: begin
            memReq = 1; adrSrc = 1;
         end
         T_MEMWB: begin
            resSrc = 2'b01; regWrite = 1; done = 1;
         end
         T_MEMWRITE: begin
            memReq = 1; memWrite = 1; adrSrc = 1; done = v.rdy;
         end
         T_EXECR: begin
            srcA = 2'b10; aluCtl = v.alu;
         end
         T_EXECI: begin
            srcA = 2'b10; srcB = 2'b01; aluCtl = v.alu;
         end
         T_ALUWB: begin
            regWrite = 1; done = 1;
         end
         T_BEQ: begin
            srcA = 2'b10; aluCtl = 3'b001; pcWrite = v.zero; done = 1;
         end
         T_JAL, T_JALR2: begin
            srcA = 2'b01; srcB = 2'b10; pcWrite = 1;
         end
         T_JALR1: begin
            srcA = 2'b10; srcB = 2'b01;
         end
         T_LUI: begin
            srcB = 2'b01; immSrc = 3'b100; aluCtl = 3'b100;
         end
         T_TRAP: begin
            trap = 1; cause = v.cause;
         end
         default: trap = 0;
      endcase
      return {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, resSrc,
              srcA, srcB, aluCtl, immSrc, done, trap, cause};
   endfunction

   function automatic logic [20:0] observed();
      return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
              ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Trap, TrapCause};
   endfunction

   // Select the instruction fields (and Zero) held for the following vectors.
   task automatic setInstr(logic [6:0] op, logic [2:0] f3, logic f7, logic zero);
      curOp = op; curF3 = f3; curF7 = f7; curZero = zero;
   endtask

   function automatic vec_t mk(tag_t t, logic rdy, logic [2:0] alu, logic cause);
      vec_t v;
      v.op = curOp; v.f3 = curF3; v.f7 = curF7; v.zero = curZero;
      v.rdy = rdy; v.tag = t; v.alu = alu; v.cause = cause;
      return v;
   endfunction

   task automatic push(tag_t t, logic rdy, logic [2:0] alu = 3'b000);
      vecs.push_back(mk(t, rdy, alu, 1'b0));
   endtask

   task automatic applyStimulus(vec_t v);
      Opcode   = v.op;
      Funct3   = v.f3;
      Funct7b5 = v.f7;
      Zero     = v.zero;
      MemReady = v.rdy;
   endtask

   task automatic checkOutput(vec_t v, string nm);
      logic [20:0] want;
      logic [20:0] got;
      want = expOut(v);
      got  = observed();
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s got=%b want=%b", nm, got, want);
      end
   endtask

   // One clock cycle: drive at the falling edge, check 1 ns later.
   task automatic step(vec_t v, string nm);
      applyStimulus(v);
      #1;
      checkOutput(v, nm);
      @(negedge clk);
   endtask

   task automatic run(tag_t t, logic rdy, logic [2:0] alu, logic cause, string nm);
      step(mk(t, rdy, alu, cause), nm);
   endtask

   // Assert reset (asynchronously, even mid-instruction), confirm every
   // output is low with MemReady high, then release on a falling edge.
   task automatic resetDut(string nm);
      logic [20:0] got;
      rst      = 1'b1;
      MemReady = 1'b1;
      Zero     = 1'b1;
      #1;
      got = observed();
      checks++;
      if (got !== 21'b0) begin
         failures++;
         $display("[TB] FAIL %s got=%b want=%b", nm, got, 21'b0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Normal instruction flows, one entry per clock cycle.
   task automatic buildTable();
      setInstr(OPC_R, 3'b000, 1'b0, 1'b0);           // add x3,x1,x2
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECR, 1, 3'b000); push(T_ALUWB, 1);
      setInstr(OPC_R, 3'b000, 1'b1, 1'b0);           // sub
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECR, 1, 3'b001); push(T_ALUWB, 1);
      setInstr(OPC_R, 3'b010, 1'b0, 1'b0);           // slt
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECR, 1, 3'b101); push(T_ALUWB, 1);
      setInstr(OPC_R, 3'b110, 1'b0, 1'b0);           // or
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECR, 1, 3'b011); push(T_ALUWB, 1);
      setInstr(OPC_I, 3'b111, 1'b0, 1'b0);           // andi
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECI, 1, 3'b010); push(T_ALUWB, 1);
      setInstr(OPC_I, 3'b000, 1'b1, 1'b0);           // addi with imm bit 30 set
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECI, 1, 3'b000); push(T_ALUWB, 1);
      setInstr(OPC_LOAD, 3'b010, 1'b0, 1'b0);        // lw, ready on 3rd cycle twice
      push(T_FETCH, 0); push(T_FETCH, 0); push(T_FETCH, 1); push(T_DECODE, 1);
      push(T_MEMADR, 1); push(T_MEMREAD, 0); push(T_MEMREAD, 0); push(T_MEMREAD, 1);
      push(T_MEMWB, 1);
      setInstr(OPC_STORE, 3'b010, 1'b0, 1'b0);       // sw with one wait
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_MEMADR, 1);
      push(T_MEMWRITE, 0); push(T_MEMWRITE, 1);
      setInstr(OPC_BRANCH, 3'b000, 1'b0, 1'b1);      // beq taken
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_BEQ, 1);
      setInstr(OPC_BRANCH, 3'b000, 1'b0, 1'b0);      // beq not taken
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_BEQ, 1);
      setInstr(OPC_JAL, 3'b000, 1'b0, 1'b0);
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_JAL, 1); push(T_ALUWB, 1);
      setInstr(OPC_JALR, 3'b000, 1'b0, 1'b0);        // jalr 0x000080E7
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_JALR1, 1); push(T_JALR2, 1);
      push(T_ALUWB, 1);
      setInstr(OPC_LUI, 3'b101, 1'b0, 1'b0);
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_LUI, 1); push(T_ALUWB, 1);
      setInstr(OPC_R, 3'b000, 1'b0, 1'b0);           // ready exactly at the limit
      push(T_FETCH, 0); push(T_FETCH, 0); push(T_FETCH, 0); push(T_FETCH, 0);
      push(T_FETCH, 1); push(T_DECODE, 1); push(T_EXECR, 1, 3'b000); push(T_ALUWB, 1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      Opcode   = 7'b0;
      Funct3   = 3'b0;
      Funct7b5 = 1'b0;
      Zero     = 1'b0;
      MemReady = 1'b0;

      buildTable();
      resetDut("reset_initial");
      foreach (vecs[i]) begin
         step(vecs[i], $sformatf("vec%0d_%s", i, vecs[i].tag.name()));
      end

      // Illegal opcode: trap with cause 0, no further memory requests.
      resetDut("reset_before_badop");
      setInstr(OPC_BAD, 3'b000, 1'b0, 1'b0);
      run(T_FETCH, 1, 3'b000, 0, "badop_fetch");
      run(T_DECODE, 1, 3'b000, 0, "badop_decode");
      for (int i = 0; i < 3; i++) run(T_TRAP, 1, 3'b000, 0, $sformatf("badop_trap%0d", i));

      // Unsupported funct3 in a register op traps after EXECR.
      resetDut("reset_clears_trap");
      setInstr(OPC_R, 3'b001, 1'b0, 1'b0);
      run(T_FETCH, 1, 3'b000, 0, "badf3_fetch");
      run(T_DECODE, 1, 3'b000, 0, "badf3_decode");
      run(T_EXECR, 1, 3'b000, 0, "badf3_execr");
      for (int i = 0; i < 2; i++) run(T_TRAP, 1, 3'b000, 0, $sformatf("badf3_trap%0d", i));

      // MemReady stuck low in FETCH: five waiting cycles, then bus-timeout trap.
      resetDut("reset_before_timeout");
      setInstr(OPC_R, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) run(T_FETCH, 0, 3'b000, 0, $sformatf("to_fetch%0d", i));
      run(T_TRAP, 1, 3'b000, 1, "to_trap0");
      run(T_TRAP, 0, 3'b000, 1, "to_trap1");

      // Reset in the middle of a load, then a clean add from FETCH.
      resetDut("reset_before_abort");
      setInstr(OPC_LOAD, 3'b010, 1'b0, 1'b0);
      run(T_FETCH, 1, 3'b000, 0, "abort_fetch");
      run(T_DECODE, 1, 3'b000, 0, "abort_decode");
      run(T_MEMADR, 1, 3'b000, 0, "abort_memadr");
      run(T_MEMREAD, 0, 3'b000, 0, "abort_memread");
      resetDut("reset_mid_load");
      setInstr(OPC_R, 3'b000, 1'b0, 1'b0);
      run(T_FETCH, 1, 3'b000, 0, "after_fetch");
      run(T_DECODE, 1, 3'b000, 0, "after_decode");
      run(T_EXECR, 1, 3'b000, 0, "after_execr");
      run(T_ALUWB, 1, 3'b000, 0, "after_aluwb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main sequencing FSM for the multi-cycle RV32I core; replaces per-instruction single-cycle decode with a Moore state machine driving one shared ALU, one unified memory port and the register file across several cycles per instruction. Sits beside the datapath: reads opcode/funct fields from the instruction register (IR) and the ALU Zero flag, and drives all mux selects and write strobes. Handles a ready-based memory handshake, a bus-timeout watchdog and an illegal-opcode trap.

Parameters:
MEM_TIMEOUT, 0, max wait cycles on MemReady before bus-error trap; 0 disables the watchdog
TO_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2**TO_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
Opcode  in  7  IR[6:0]
Funct3  in  3  IR[14:12]
Funct7b5  in  1  IR[30]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request
MemWrite  out  1  store strobe, valid with MemReq
AdrSrc  out  1  0 = PC, 1 = ALUOut
IRWrite  out  1  latch IR and OldPC
PCWrite  out  1  PC load enable
RegWrite  out  1  register-file write enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  out  2  00 = rs2, 01 = Imm, 10 = const 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 pass-B (LUI), 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
Trap  out  1  sticky; high after an illegal opcode or bus timeout
TrapCause  out  1  0 = illegal opcode, 1 = bus timeout

Behaviour:
- Reset: state = FETCH; timeout counter = 0; Trap = 0; TrapCause = 0. All strobes (MemReq, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone) are 0 while rst is high. Selects and ALUControl are 0.
- Outputs are Moore, decoded from state only. The exceptions are PCWrite in BEQ (= Zero) and the MemReady-qualified strobes.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. The state holds until MemReady. In the MemReady cycle, IRWrite=1 and PCWrite=1 (PC <= PC+4), then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add (branch target into ALUOut). Next state by Opcode:
  0000011 / 0100011 -> MEMADR
  0110011 -> EXECR
  0010011 -> EXECI
  1100011 -> BEQ
  1101111 -> JAL
  1100111 -> JALR1
  0110111 -> LUI
  anything else -> TRAP (cause 0)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=001 for store, 000 for load. Go to MEMWRITE for store, MEMREAD for load.
- MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. On MemReady assert InstrDone and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. Both go to ALUWB.
- ALU decode for EXECR/EXECI:
  funct3 000 -> add; sub only in EXECR with Funct7b5=1
  funct3 110 -> or
  funct3 111 -> and
  funct3 010 -> slt
  any other funct3 -> TRAP (cause 0)
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, InstrDone=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <= target), then ALUWB (rd <= OldPC+4).
- JALR1: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add, then JALR2.
- JALR2: same signals as JAL, then ALUWB. The JALR target LSB is cleared in the datapath, not here.
- LUI: ALUSrcB=01, ImmSrc=100, ALUControl=100, then ALUWB.
- Watchdog (MEM_TIMEOUT > 0):
  - The counter increments each cycle in FETCH/MEMREAD/MEMWRITE while MemReady=0, and clears on MemReady or on any other state.
  - When count == MEM_TIMEOUT with MemReady=0, go to TRAP (cause 1).
  - MemReady in the same cycle as the limit wins: the access completes normally.
- TRAP: all strobes 0, Trap=1. Absorbing until rst.
- MemReady outside the memory states is ignored.
- rst asserted mid-instruction aborts immediately with no partial writes; the next fetch starts the cycle after rst deasserts.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - localparam encodings for ALUControl, ImmSrc, ResultSrc, ALUSrcA, ALUSrcB
- Sub-module alu_decoder: combinational Funct3/Funct7b5/is_rtype -> ALUControl plus illegal flag.

Test Plan:
- rst pulse, MemReady tied 1, IR = add x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=000; RegWrite=1 for exactly one cycle; InstrDone at cycle 4.
- lw with MemReady delayed 3 cycles in both FETCH and MEMREAD -> MemReq held steady; IRWrite once; ResultSrc=01 in MEMWB; 9 cycles total.
- beq with Zero=1 then Zero=0 -> PCWrite=1 only in the Zero=1 instance; each instruction takes 3 cycles.
- jalr (0x000080E7) -> ImmSrc=000 in JALR1; PCWrite in JALR2; RegWrite in ALUWB with ResultSrc=00.
- Opcode 0x7F, and separately funct3=001 in EXECR -> Trap=1, TrapCause=0; no further MemReq until rst.
- MEM_TIMEOUT=4, MemReady stuck 0 in FETCH -> TRAP after 5 cycles with TrapCause=1; repeat with MemReady=1 in the limit cycle -> normal DECODE, no trap.
